convolution_job_scheduler: RTL
==============================

CONVOLUTION_JOB_SCHEDULER -- requirements
Module: convolution_job_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_SIZEY, default 5, meaning the width of the Y-sequence length.
REQ-002 The block SHALL have parameter DATA_WIDTH_MEMZ_ADDR, default 6, meaning the width of the Z address and of the Z-sample count.
REQ-003 The block SHALL have parameter SIZEH, default 10, meaning the fixed kernel length used by the convolution processor.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the watchdog limit in cycles, held in an 8-bit counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port job_valid, input, 1 bit: the host requests a job.
REQ-008 The block SHALL have port job_sizeY, input, DATA_WIDTH_SIZEY bits: the job Y length.
REQ-009 The block SHALL have port job_ready, output, 1 bit: the scheduler can accept a job.
REQ-010 The block SHALL have port cp_sizeY, output, DATA_WIDTH_SIZEY bits: the latched length driven to the processor.
REQ-011 The block SHALL have port cp_start, output, 1 bit: the start pulse to the processor.
REQ-012 The block SHALL have port cp_rst, output, 1 bit: the active-high processor reset request; the top level inverts it to rstn.
REQ-013 The block SHALL have port cp_busy, input, 1 bit: the processor busy flag.
REQ-014 The block SHALL have port cp_done, input, 1 bit: the processor done flag.
REQ-015 The block SHALL have port cp_writeZ, input, 1 bit: the processor Z-write strobe.
REQ-016 The block SHALL have port cp_memZ_addr, input, DATA_WIDTH_MEMZ_ADDR bits: the processor Z address.
REQ-017 The block SHALL have port job_done, output, 1 bit: a one-cycle pulse on successful completion.
REQ-018 The block SHALL have port job_err, output, 1 bit: a one-cycle pulse on failure.
REQ-019 The block SHALL have port err_code, output, 3 bits: the last error code, held until the next accepted job.
REQ-020 The block SHALL have port zcount, output, DATA_WIDTH_MEMZ_ADDR bits: the Z writes counted in the current or last job.

Function
REQ-021 The state machine SHALL have exactly the states IDLE, LAUNCH, WAIT_BUSY, RUN, COMPLETE and ERROR.
REQ-022 job_ready SHALL be high only in IDLE; a job is accepted on a cycle where job_valid and job_ready are both high.
REQ-023 On accept, the block SHALL latch job_sizeY into cp_sizeY and hold it unchanged until the next accept.
REQ-024 On accept, the block SHALL clear zcount and err_code, and SHALL compute expected = job_sizeY + SIZEH - 1 at DATA_WIDTH_MEMZ_ADDR width.
REQ-025 On accept with job_sizeY = 0, the block SHALL go to ERROR with err_code 3'b001 and SHALL NOT assert cp_start.
REQ-026 On accept with job_sizeY nonzero, the block SHALL go to LAUNCH.
REQ-027 In LAUNCH, cp_start SHALL be high for exactly one cycle, one cycle after accept, and the next state SHALL be WAIT_BUSY.
REQ-028 In WAIT_BUSY, cp_busy high SHALL move the block to RUN.
REQ-029 In WAIT_BUSY, TIMEOUT cycles without cp_busy SHALL move the block to ERROR with err_code 3'b010.
REQ-030 In RUN, each cycle with cp_writeZ high SHALL compare cp_memZ_addr against zcount, increment zcount, and reload the watchdog.
REQ-031 In RUN, a cp_memZ_addr that differs from zcount on a write SHALL move the block to ERROR with err_code 3'b011.
REQ-032 In RUN, cp_done high with zcount (including a same-cycle write) equal to expected SHALL move the block to COMPLETE.
REQ-033 In RUN, cp_done high with any other zcount SHALL move the block to ERROR with err_code 3'b100.
REQ-034 In RUN, TIMEOUT cycles without cp_writeZ or cp_done SHALL move the block to ERROR with err_code 3'b101.
REQ-035 In RUN, a write beyond expected SHALL move the block to ERROR with err_code 3'b110, and zcount SHALL saturate at expected+1.
REQ-036 When several error conditions occur in the same cycle, the lowest error code SHALL win.
REQ-037 COMPLETE SHALL assert job_done for one cycle and then return to IDLE.
REQ-038 ERROR SHALL assert job_err and cp_rst for one cycle and then return to IDLE.
REQ-039 cp_writeZ and cp_done SHALL be ignored in IDLE, COMPLETE and ERROR.
REQ-040 All outputs SHALL be registered, with no combinational path from input to output except job_ready, which decodes the state.

Reset
REQ-041 While rst is high at a clock edge, the block SHALL enter IDLE.
REQ-042 While rst is high at a clock edge, cp_sizeY, zcount and err_code SHALL be 0 and the watchdog SHALL be cleared.
REQ-043 While rst is high at a clock edge, cp_start, cp_rst, job_done and job_err SHALL be 0, and job_ready SHALL be 1 from the first cycle after reset.
REQ-044 A reset asserted in any state, including mid-RUN, SHALL abort the job with no job_done or job_err pulse.
REQ-045 A reset SHALL NOT assert cp_rst; the system reset resets the processor directly.

Verification
REQ-046 The bench SHALL cover: job_sizeY=5 with a model processor that writes addresses 0..13 then asserts done -> cp_start high one cycle after accept, then job_done, zcount=14, err_code=0.
REQ-047 The bench SHALL cover: job_sizeY=0 -> job_err one cycle after accept, err_code=3'b001, cp_start never high.
REQ-048 The bench SHALL cover: start with busy never asserted -> job_err after 255 cycles in WAIT_BUSY, err_code=3'b010, cp_rst high one cycle.
REQ-049 The bench SHALL cover: job_sizeY=3 with the model skipping address 4 -> job_err, err_code=3'b011.
REQ-050 The bench SHALL cover: job_sizeY=3 with done after 10 writes instead of 12 -> job_err, err_code=3'b100, zcount=10.
REQ-051 The bench SHALL cover: rst pulsed after 6 writes of a job_sizeY=5 run -> IDLE next cycle, job_ready=1, zcount=0, no done or err pulse, and the next job completes normally.

Source files
------------

// File: rtl/convolution_job_scheduler.sv
// Job scheduler for the convolution processor: launches a job, polices
// the Z-write stream against the expected length and reports done/error.
module convolution_job_scheduler #(
  parameter int DATA_WIDTH_SIZEY     = 5,
  parameter int DATA_WIDTH_MEMZ_ADDR = 6,
  parameter int SIZEH                = 10,
  parameter int TIMEOUT              = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            job_valid,
  input  logic [DATA_WIDTH_SIZEY-1:0]     job_sizeY,
  output logic                            job_ready,
  output logic [DATA_WIDTH_SIZEY-1:0]     cp_sizeY,
  output logic                            cp_start,
  output logic                            cp_rst,
  input  logic                            cp_busy,
  input  logic                            cp_done,
  input  logic                            cp_writeZ,
  input  logic [DATA_WIDTH_MEMZ_ADDR-1:0] cp_memZ_addr,
  output logic                            job_done,
  output logic                            job_err,
  output logic [2:0]                      err_code,
  output logic [DATA_WIDTH_MEMZ_ADDR-1:0] zcount
);

  localparam int YW = DATA_WIDTH_SIZEY;
  localparam int ZW = DATA_WIDTH_MEMZ_ADDR;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LAUNCH    = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] COMPLETE  = 3'd4;
  localparam logic [2:0] ERROR     = 3'd5;

  localparam logic [2:0] E_NONE  = 3'b000;
  localparam logic [2:0] E_SIZE  = 3'b001;
  localparam logic [2:0] E_BUSY  = 3'b010;
  localparam logic [2:0] E_ADDR  = 3'b011;
  localparam logic [2:0] E_DONE  = 3'b100;
  localparam logic [2:0] E_STALL = 3'b101;
  localparam logic [2:0] E_OVER  = 3'b110;

  localparam logic [7:0]    WD_LAST = 8'(TIMEOUT - 1);
  localparam logic [ZW-1:0] TAP_M1  = ZW'(SIZEH - 1);

  logic [2:0]    state_q, state_d;
  logic [YW-1:0] sizey_q, sizey_d;
  logic [ZW-1:0] zcount_q, zcount_d;
  logic [ZW-1:0] expected_q, expected_d;
  logic [2:0]    err_q, err_d;
  logic [7:0]    wdog_q, wdog_d;
  logic          start_q;
  logic          cprst_q;
  logic          done_q;
  logic          jerr_q;

  logic [ZW-1:0] z_sat;
  logic [ZW-1:0] z_step;
  logic [ZW-1:0] z_eff;
  logic          addr_bad;
  logic          over;
  logic          done_bad;
  logic          quiet;
  logic          stall;

  // zcount stops at expected+1 so an overrun stays visible
  assign z_sat    = expected_q + ZW'(1);
  assign z_step   = (zcount_q == z_sat) ? zcount_q
                                        : zcount_q + ZW'(1);
  assign z_eff    = cp_writeZ ? z_step : zcount_q;
  assign addr_bad = cp_writeZ && (cp_memZ_addr != zcount_q);
  assign over     = cp_writeZ && (zcount_q >= expected_q);
  assign done_bad = cp_done && (z_eff != expected_q);
  assign quiet    = !cp_writeZ && !cp_done;
  assign stall    = quiet && (wdog_q == WD_LAST);

  always_comb begin
    state_d    = state_q;
    sizey_d    = sizey_q;
    zcount_d   = zcount_q;
    expected_d = expected_q;
    err_d      = err_q;
    wdog_d     = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          sizey_d    = job_sizeY;
          zcount_d   = '0;
          err_d      = E_NONE;
          wdog_d     = '0;
          expected_d = ZW'(job_sizeY) + TAP_M1;
          if (job_sizeY == '0) begin
            state_d = ERROR;
            err_d   = E_SIZE;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
        wdog_d  = '0;
      end
      WAIT_BUSY: begin
        if (cp_busy) begin
          state_d = RUN;
          wdog_d  = '0;
        end else if (wdog_q == WD_LAST) begin
          state_d = ERROR;
          err_d   = E_BUSY;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      RUN: begin
        zcount_d = z_eff;
        if (cp_writeZ) begin
          wdog_d = '0;
        end else if (quiet) begin
          wdog_d = wdog_q + 8'd1;
        end
        // ordered by error code so the lowest code wins
        if (addr_bad) begin
          state_d = ERROR;
          err_d   = E_ADDR;
        end else if (cp_done) begin
          if (done_bad) begin
            state_d = ERROR;
            err_d   = E_DONE;
          end else begin
            state_d = COMPLETE;
          end
        end else if (stall) begin
          state_d = ERROR;
          err_d   = E_STALL;
        end else if (over) begin
          state_d = ERROR;
          err_d   = E_OVER;
        end
      end
      COMPLETE: state_d = IDLE;
      ERROR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sizey_q    <= '0;
      zcount_q   <= '0;
      expected_q <= '0;
      err_q      <= E_NONE;
      wdog_q     <= '0;
      start_q    <= 1'b0;
      cprst_q    <= 1'b0;
      done_q     <= 1'b0;
      jerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sizey_q    <= sizey_d;
      zcount_q   <= zcount_d;
      expected_q <= expected_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
      start_q    <= (state_d == LAUNCH);
      cprst_q    <= (state_d == ERROR);
      done_q     <= (state_d == COMPLETE);
      jerr_q     <= (state_d == ERROR);
    end
  end

  assign job_ready = (state_q == IDLE);
  assign cp_sizeY  = sizey_q;
  assign cp_start  = start_q;
  assign cp_rst    = cprst_q;
  assign job_done  = done_q;
  assign job_err   = jerr_q;
  assign err_code  = err_q;
  assign zcount    = zcount_q;

endmodule
